// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the programmable tick generator.
package tick_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tg_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int TG_WIDTH       = 25;
    localparam int TG_DEFAULT_DIV = 2500000;
    localparam int TG_TCW         = 16;

endpackage

// File: rtl/tick_gen_count.sv
// WIDTH-bit period counter: synchronous clear, enable, and terminal compare against the active divisor.
module tick_gen_count
    import tick_gen_pkg::*;
#(
    parameter int WIDTH = TG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] count_o,
    output logic             term_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // div_i is never 0, so div_i-1 cannot underflow and count never passes it
    assign term_o  = (count_q == (div_i - WIDTH'(1)));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = term_o ? '0 : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tick_generator.sv
// Programmable tick generator: periodic / one-shot divider with pause, start and stop.
// Optional wrapping tick counter enabled by TICK_GEN_TICK_COUNT_EN.
//
// state   | meaning
// ST_IDLE | count held at 0, divisor follows shadow, no ticks
// ST_RUN  | counting; tick at count == div_q-1
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int WIDTH       = TG_WIDTH,
    parameter int DEFAULT_DIV = TG_DEFAULT_DIV,
    parameter int TCW         = TG_TCW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             busy,
`ifdef TICK_GEN_TICK_COUNT_EN
    output logic [TCW-1:0]   tick_count,
`endif
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    tg_state_e        state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             tick_q;

    logic go;
    logic fire;
    logic term;
    logic cnt_en;
    logic cnt_clr;

    assign go      = start && !stop;
    assign cnt_en  = (state_q == ST_RUN) && en;
    assign cnt_clr = (state_q == ST_IDLE) || start || stop;
    // start and stop both pre-empt a coincident terminal count
    assign fire    = cnt_en && term && !start && !stop;

    tick_gen_count #(
        .WIDTH (WIDTH)
    ) u_count (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .div_i   (div_q),
        .count_o (count),
        .term_o  (term)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    mode_d = mode;
                end else if (fire && (mode_q == MODE_ONESHOT)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Active divisor only changes at period boundaries, so a period is never cut short
    always_comb begin
        shadow_d = shadow_q;
        if (div_load) begin
            shadow_d = (div_in == '0) ? WIDTH'(1) : div_in;
        end
        div_d = div_q;
        if ((state_q == ST_IDLE) || go || fire) begin
            div_d = shadow_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_PERIODIC;
            div_q    <= DIV_RST;
            shadow_q <= DIV_RST;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            tick_q   <= fire;
        end
    end

    assign tick = tick_q;
    assign busy = (state_q == ST_RUN);

`ifdef TICK_GEN_TICK_COUNT_EN
    logic [TCW-1:0] tcount_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcount_q <= '0;
        end else if (fire) begin
            tcount_q <= tcount_q + TCW'(1);
        end
    end

    assign tick_count = tcount_q;
`else
    logic [31:0] unused_tcw;
    assign unused_tcw = 32'(TCW);
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: directed scenarios plus randomized traffic against a behavioural model.
module tb_tick_generator;

    localparam int WIDTH = 8;
    localparam int DEFV  = 5;
    localparam int TCW   = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             mode = 1'b0;
    logic             div_load = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             tick;
    logic             busy;
    logic [WIDTH-1:0] count;
`ifdef TICK_GEN_TICK_COUNT_EN
    logic [TCW-1:0]   tick_count;
`endif

    int checks = 0;
    int errors = 0;

    tick_generator #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFV),
        .TCW         (TCW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .div_load   (div_load),
        .div_in     (div_in),
        .tick       (tick),
        .busy       (busy),
`ifdef TICK_GEN_TICK_COUNT_EN
        .tick_count (tick_count),
`endif
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: running flag, elapsed enabled cycles in the current period, divisors, tick total
    bit m_run = 0;
    bit m_mode = 0;
    int m_div = DEFV;
    int m_shadow = DEFV;
    int m_cnt = 0;
    bit m_tick = 0;
    int m_tc = 0;
    bit m_go, m_fire;
    int m_new_shadow;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_mode = 0; m_div = DEFV; m_shadow = DEFV;
            m_cnt = 0; m_tick = 0; m_tc = 0;
        end else begin
            m_go   = start && !stop;
            m_fire = m_run && en && !start && !stop && (m_cnt == m_div - 1);
            m_new_shadow = div_load ? ((int'(div_in) == 0) ? 1 : int'(div_in)) : m_shadow;
            if (!m_run || m_go || m_fire) m_div = m_new_shadow;
            m_shadow = m_new_shadow;
            m_tick = m_fire;
            if (m_fire) m_tc = (m_tc + 1) % (1 << TCW);
            if (m_run && stop) begin
                m_run = 0; m_cnt = 0;
            end else if (m_go) begin
                m_run = 1; m_cnt = 0; m_mode = mode;
            end else if (m_run && en) begin
                if (m_fire) begin
                    m_cnt = 0;
                    if (m_mode) m_run = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("model_tick", int'(tick), int'(m_tick));
            chk("model_busy", int'(busy), int'(m_run));
            chk("model_count", int'(count), m_cnt);
`ifdef TICK_GEN_TICK_COUNT_EN
            chk("model_tick_count", int'(tick_count), m_tc);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_div(input int d);
        div_load = 1'b1;
        div_in   = WIDTH'(d);
        cyc(1);
        div_load = 1'b0;
    endtask

    // Caller has raised start; returns the edge offset (relative to the start edge) of the first tick
    task automatic wait_tick(output int edges);
        edges = -1;
        for (int k = 1; k <= 200; k++) begin
            cyc(1);
            start = 1'b0;
            if (tick) begin
                edges = k - 1;
                return;
            end
        end
    endtask

    task automatic wait_gap(output int gap);
        gap = -1;
        for (int k = 1; k <= 200; k++) begin
            cyc(1);
            if (tick) begin
                gap = k;
                return;
            end
        end
    endtask

    initial begin
        int e, g, n;

        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_tick", int'(tick), 0);

        // Default divisor 5, periodic
        en = 1'b1; mode = 1'b0; start = 1'b1;
        wait_tick(e);
        chk("periodic_first_tick", e, 5);
        chk("periodic_busy", int'(busy), 1);
        wait_gap(g);
        chk("periodic_gap", g, 5);
        wait_gap(g);
        chk("periodic_gap2", g, 5);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // One-shot with divisor 3 loaded in IDLE
        load_div(3);
        mode = 1'b1; start = 1'b1;
        wait_tick(e);
        chk("oneshot_tick", e, 3);
        chk("oneshot_busy_fall", int'(busy), 0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (tick) n++;
        end
        chk("oneshot_no_more", n, 0);

        // Divisor 4 with a 2-cycle pause
        load_div(4);
        mode = 1'b0; start = 1'b1;
        wait_tick(e);
        chk("div4_first", e, 4);
        cyc(1);
        chk("pause_count_a", int'(count), 1);
        en = 1'b0;
        cyc(1);
        chk("pause_count_b", int'(count), 1);
        cyc(1);
        chk("pause_count_c", int'(count), 1);
        en = 1'b1;
        wait_gap(g);
        chk("pause_period", g + 3, 6);

        // Divisor change mid-period, then divisor 0 -> every cycle
        cyc(1);
        load_div(7);
        wait_gap(g);
        chk("reload_cur_period", g + 2, 4);
        wait_gap(g);
        chk("reload_next_period", g, 7);
        load_div(0);
        wait_gap(g);
        chk("div0_cur_period", g + 1, 7);
        wait_gap(g);
        chk("div0_gap", g, 1);
        wait_gap(g);
        chk("div0_gap2", g, 1);
        chk("div0_count", int'(count), 0);

        // Stop on terminal count
        stop = 1'b1; cyc(1); stop = 1'b0;
        load_div(4);
        start = 1'b1;
        wait_tick(e);
        chk("div4_again", e, 4);
        cyc(3);
        chk("pre_stop_count", int'(count), 3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("stop_term_tick", int'(tick), 0);
        chk("stop_term_busy", int'(busy), 0);
        chk("stop_term_count", int'(count), 0);

        // start+stop together, in IDLE and in RUN
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        chk("ss_idle_busy", int'(busy), 0);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(2);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        chk("ss_run_busy", int'(busy), 0);
        chk("ss_run_count", int'(count), 0);
        chk("ss_run_tick", int'(tick), 0);

        // Restart while running
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(2);
        chk("restart_pre_count", int'(count), 2);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("restart_count", int'(count), 0);
        chk("restart_busy", int'(busy), 1);
        wait_gap(g);
        chk("restart_gap", g, 4);

        // Asynchronous reset mid-run
        cyc(2);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_tick", int'(tick), 0);
`ifdef TICK_GEN_TICK_COUNT_EN
        chk("arst_tick_count", int'(tick_count), 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        cyc(1);

`ifdef TICK_GEN_TICK_COUNT_EN
        // Tick counter wraps after 2^TCW ticks
        load_div(0);
        start = 1'b1; cyc(1); start = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            if (tick) n++;
            if (n < 8) cyc(1);
        end
        chk("tc_ticks_seen", n, 8);
        chk("tc_wrapped", int'(tick_count), 0);
        stop = 1'b1; cyc(1); stop = 1'b0;
`endif

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            en       = ($urandom_range(0, 9) != 0);
            start    = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            mode     = 1'($urandom_range(0, 1));
            div_load = ($urandom_range(0, 24) == 0);
            div_in   = WIDTH'($urandom_range(0, 6));
            cyc(1);
        end
        start = 1'b0; stop = 1'b0; div_load = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
# tick_generator

Parametrised, programmable tick generator: divides `clk` by a runtime-loadable divisor and emits a one-cycle `tick` pulse, in periodic or one-shot mode, with pause (`en`), start and stop control. Successor to the fixed 25-bit modulo counter. Drives timebases for display scanning, debouncers and stepping logic. The terminal count is compared synchronously, so no counter state is ever cleared through the asynchronous reset path.

## Interface
- `WIDTH`, 25: counter and divisor width.
- `DEFAULT_DIV`, 2500000: divisor value after reset. Must be ≥1 and < 2^WIDTH.
- `TCW`, 16: width of `tick_count`. Used only with `TICK_GEN_TICK_COUNT_EN`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: count enable; low pauses the counter.
- `start` in 1: begin a run from count 0.
- `stop` in 1: abort the run and return to IDLE.
- `mode` in 1: 0 = periodic, 1 = one-shot. Sampled on `start`.
- `div_load` in 1: load `div_in` into the shadow divisor.
- `div_in` in WIDTH: new divisor; 0 is treated as 1.
- `tick` out 1: registered one-cycle pulse at terminal count.
- `busy` out 1: high while in RUN.
- `count` out WIDTH: current counter value.
- `tick_count` out TCW: number of ticks, wrapping. Present only with the macro.

## Operation
- The FSM has two states, IDLE and RUN.
- IDLE:
  - `count` is held at 0 and `tick` is 0.
  - `start` moves the FSM to RUN, sets `count` to 0, and latches `mode` into `mode_q`.
- RUN:
  - When `en`=1, `count` increments each cycle.
  - When `en`=1 and `count == div_q-1`, `count` wraps to 0 and `tick` is set to 1 for one cycle.
  - In one-shot mode (`mode_q`=1), that terminal event also moves the FSM to IDLE.
  - When `en`=0, `count` freezes and `tick` is 0. `en` has no effect in IDLE.
- `stop` moves the FSM from RUN to IDLE and sets `count` to 0. No tick is produced, even if `stop` coincides with the terminal count.
- Simultaneous `start` and `stop`: `stop` wins.
- `start` while in RUN restarts the run: `count` goes to 0, `mode_q` is re-latched, and no tick is produced that cycle.
- Divisor:
  - `div_load` writes `div_in` into `div_shadow`.
  - `div_shadow` is copied to `div_q` on the next terminal event, on `start`, or immediately if in IDLE.
  - The active period therefore never changes mid-period.
  - A `div_in` of 0 is stored as 1.
- Divisor of 1: `count` stays at 0 and `tick` is high on every enabled RUN cycle.
- Arithmetic:
  - All compares and increments are WIDTH-bit and unsigned.
  - `count` never exceeds `div_q-1`, so no natural wrap occurs.

## Timing
- Reset values:
  - FSM in IDLE.
  - `count`=0, `tick`=0, `busy`=0, `tick_count`=0.
  - `div_q` and `div_shadow` = `DEFAULT_DIV`.
  - `mode_q`=0.
- `start` sampled at edge E0:
  - `busy` and RUN are in effect from E0.
  - With `en` held high, the first `tick` is high in the cycle after edge E0+D, where D = `div_q`.
  - Subsequent periodic ticks occur every D cycles exactly.
- Each cycle with `en` low extends the period by one cycle.
- One-shot: `busy` falls at the same edge that raises `tick`.
- Reset asserted mid-run: all state returns immediately to reset values; no tick is emitted.

## Configuration
- Macro: `TICK_GEN_TICK_COUNT_EN`.
- Defined:
  - Adds the `tick_count` port, a TCW-bit register that increments on every tick and wraps from 2^TCW-1 to 0.
  - `start` does not clear it; only `reset` clears it.
- Undefined: the port and the register are absent. All other behaviour is identical.

## Structure
- Package `tick_gen_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`),
  - the mode constants (`MODE_PERIODIC`, `MODE_ONESHOT`),
  - the default `WIDTH` and `DEFAULT_DIV` constants.
- One sub-module, `tick_gen_count`, contains the WIDTH-bit counter with clear, enable and terminal-compare against `div_q`, and outputs the terminal flag.
- The top level holds the FSM, the divisor shadow/active registers, the tick register and the optional tick counter.

## Test plan
- Reset, then `start` with `DEFAULT_DIV` overridden to 5, periodic mode, `en`=1: ticks occur every 5 cycles, first tick 5 cycles after `start`; `busy`=1 throughout.
- One-shot mode, `div_in`=3 loaded in IDLE, `start`: exactly one tick 3 cycles later; `busy` falls at that edge; no further ticks.
- Periodic run with div 4, `en` low for 2 cycles mid-period: that period is 6 cycles and `count` holds its value while paused.
- `div_load` of 7 mid-period with div 4: current period completes at 4 cycles, next period is 7 cycles. `div_in`=0 gives a tick every cycle.
- `stop` coinciding with the terminal count, and `start`+`stop` in the same cycle: no tick, IDLE, `count`=0.
- `reset` asserted mid-run: outputs return to reset values immediately. With the macro defined, `tick_count` wraps after 2^TCW ticks (test with TCW=3: wraps after 8 ticks).
